// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcodes, FSM states and bubble fields for hazard_ctrl
//
// Purpose: constants and types shared by hazard_ctrl and its sub-module.
// Ports: none (package).

package hazard_pkg;

  localparam logic [4:0] OP_NOP = 5'h1f;
  localparam logic [4:0] OP_LD  = 5'h08;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_BEQ = 5'h10;
  localparam logic [4:0] OP_ST  = 5'h09;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MULBUSY = 2'd1,
    ST_FLUSH2  = 2'd2
  } state_t;

  // Instruction fields that ID/EX can be loaded with on a stall.
  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] rd;
    logic [3:0] r1;
    logic [3:0] r2;
  } fields_t;

  localparam logic [4:0] BUBBLE_OPCODE = OP_NOP;
  localparam logic [2:0] BUBBLE_RD     = 3'd0;
  localparam logic [3:0] BUBBLE_R1     = 4'd0;
  localparam logic [3:0] BUBBLE_R2     = 4'd0;

  localparam fields_t BUBBLE_FIELDS = '{
    opcode: BUBBLE_OPCODE,
    rd:     BUBBLE_RD,
    r1:     BUBBLE_R1,
    r2:     BUBBLE_R2
  };

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - loadable 4-bit down-counter with zero flag
//
// Purpose: counts the remaining MUL stall cycles while hazard_ctrl is in MULBUSY.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-low reset (count clears to 0)
//   load      in  load load_val this cycle (wins over dec)
//   load_val  in  value to load
//   dec       in  decrement; saturates at 0
//   cnt       out current count
//   zero      out count is 0

module stall_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / MUL-occupancy / branch-flush hazard controller
//
// Purpose: drives the stall/flush controls of the ID/EX pipeline register and the
// PC / IF-ID hold strobes. All outputs are combinational (zero-cycle latency).
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   IFID_OPCODE/R1_ADDR/R2_ADDR    instruction in IF/ID
//   IDEX_OPCODE/RD_ADDR/R1/R2_ADDR instruction in ID/EX
//   BRANCH_TAKEN                   EX branch outcome (meaningful only for BEQ)
//   STALL, FLUSH                   ID/EX loads STALL_* fields / loads a NOP
//   PC_HOLD, IFID_HOLD             PC and IF/ID keep their values
//   STALL_OPCODE/RD/R1/R2_ADDR     replay or bubble fields for ID/EX

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IFID_OPCODE,
  input  logic [3:0] IFID_R1_ADDR,
  input  logic [3:0] IFID_R2_ADDR,
  input  logic [4:0] IDEX_OPCODE,
  input  logic [2:0] IDEX_RD_ADDR,
  input  logic [3:0] IDEX_R1_ADDR,
  input  logic [3:0] IDEX_R2_ADDR,
  input  logic       BRANCH_TAKEN,
  output logic       STALL,
  output logic       FLUSH,
  output logic       PC_HOLD,
  output logic       IFID_HOLD,
  output logic [4:0] STALL_OPCODE,
  output logic [2:0] STALL_RD_ADDR,
  output logic [3:0] STALL_R1_ADDR,
  output logic [3:0] STALL_R2_ADDR
);

  // The detect cycle in RUN is the first stall, so MULBUSY needs MUL_CYCLES-2 more.
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t  state_q, state_d;
  fields_t cap_q, cap_d;

  logic    cnt_load, cnt_dec, cnt_zero;
  logic [3:0] cnt;

  logic    stall_c, flush_c, hold_c;
  fields_t out_c;
  fields_t idex_fields;

  logic    branch_hit, mul_hit, load_use_hit;

  assign idex_fields = '{
    opcode: IDEX_OPCODE,
    rd:     IDEX_RD_ADDR,
    r1:     IDEX_R1_ADDR,
    r2:     IDEX_R2_ADDR
  };

  assign branch_hit = BRANCH_TAKEN && (IDEX_OPCODE == OP_BEQ);
  assign mul_hit    = (IDEX_OPCODE == OP_MUL) && (MUL_CYCLES > 1);

  // A NOP in IF/ID carries no meaningful r2, so only r1 is compared then.
  assign load_use_hit = (IDEX_OPCODE == OP_LD) && (IDEX_RD_ADDR != 3'd0) &&
                        (({1'b0, IDEX_RD_ADDR} == IFID_R1_ADDR) ||
                         ((IFID_OPCODE != OP_NOP) && ({1'b0, IDEX_RD_ADDR} == IFID_R2_ADDR)));

  stall_counter u_stall_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    hold_c   = 1'b0;
    out_c    = BUBBLE_FIELDS;

    case (state_q)
      ST_RUN: begin
        if (branch_hit) begin
          flush_c = 1'b1;
          state_d = ST_FLUSH2;
        end else if (mul_hit) begin
          stall_c  = 1'b1;
          hold_c   = 1'b1;
          out_c    = idex_fields;
          cap_d    = idex_fields;
          cnt_load = 1'b1;
          state_d  = ST_MULBUSY;
        end else if (load_use_hit) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
        end
      end
      ST_MULBUSY: begin
        if (!cnt_zero) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          out_c   = cap_q;
          cnt_dec = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH2: begin
        flush_c = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cap_q   <= BUBBLE_FIELDS;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Outputs are forced to their idle values while reset is held, independent of inputs.
  assign STALL         = rst & stall_c;
  assign FLUSH         = rst & flush_c;
  assign PC_HOLD       = rst & hold_c;
  assign IFID_HOLD     = rst & hold_c;
  assign STALL_OPCODE  = rst ? out_c.opcode : BUBBLE_OPCODE;
  assign STALL_RD_ADDR = rst ? out_c.rd     : BUBBLE_RD;
  assign STALL_R1_ADDR = rst ? out_c.r1     : BUBBLE_R1;
  assign STALL_R2_ADDR = rst ? out_c.r2     : BUBBLE_R2;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ifid_opcode;
  logic [3:0] ifid_r1, ifid_r2;
  logic [4:0] idex_opcode;
  logic [2:0] idex_rd;
  logic [3:0] idex_r1, idex_r2;
  logic       branch_taken;

  logic       stall, flush, pc_hold, ifid_hold;
  logic [4:0] s_op;
  logic [2:0] s_rd;
  logic [3:0] s_r1, s_r2;

  logic       u1_stall, u1_flush, u1_pc_hold, u1_ifid_hold;
  logic [4:0] u1_op;
  logic [2:0] u1_rd;
  logic [3:0] u1_r1, u1_r2;

  int tests;
  int fails;

  hazard_ctrl #(.MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .IFID_OPCODE(ifid_opcode), .IFID_R1_ADDR(ifid_r1), .IFID_R2_ADDR(ifid_r2),
    .IDEX_OPCODE(idex_opcode), .IDEX_RD_ADDR(idex_rd),
    .IDEX_R1_ADDR(idex_r1), .IDEX_R2_ADDR(idex_r2),
    .BRANCH_TAKEN(branch_taken),
    .STALL(stall), .FLUSH(flush), .PC_HOLD(pc_hold), .IFID_HOLD(ifid_hold),
    .STALL_OPCODE(s_op), .STALL_RD_ADDR(s_rd),
    .STALL_R1_ADDR(s_r1), .STALL_R2_ADDR(s_r2)
  );

  hazard_ctrl #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .IFID_OPCODE(ifid_opcode), .IFID_R1_ADDR(ifid_r1), .IFID_R2_ADDR(ifid_r2),
    .IDEX_OPCODE(idex_opcode), .IDEX_RD_ADDR(idex_rd),
    .IDEX_R1_ADDR(idex_r1), .IDEX_R2_ADDR(idex_r2),
    .BRANCH_TAKEN(branch_taken),
    .STALL(u1_stall), .FLUSH(u1_flush), .PC_HOLD(u1_pc_hold), .IFID_HOLD(u1_ifid_hold),
    .STALL_OPCODE(u1_op), .STALL_RD_ADDR(u1_rd),
    .STALL_R1_ADDR(u1_r1), .STALL_R2_ADDR(u1_r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full control/field output vector of the MUL_CYCLES=3 instance.
  task automatic chk_all(input string tag, input logic e_stall, input logic e_flush,
                         input logic e_hold, input logic [4:0] e_op, input logic [2:0] e_rd,
                         input logic [3:0] e_r1, input logic [3:0] e_r2);
    chk({tag, ".stall"},     {31'd0, stall},     {31'd0, e_stall});
    chk({tag, ".flush"},     {31'd0, flush},     {31'd0, e_flush});
    chk({tag, ".pc_hold"},   {31'd0, pc_hold},   {31'd0, e_hold});
    chk({tag, ".ifid_hold"}, {31'd0, ifid_hold}, {31'd0, e_hold});
    chk({tag, ".op"},        {27'd0, s_op},      {27'd0, e_op});
    chk({tag, ".rd"},        {29'd0, s_rd},      {29'd0, e_rd});
    chk({tag, ".r1"},        {28'd0, s_r1},      {28'd0, e_r1});
    chk({tag, ".r2"},        {28'd0, s_r2},      {28'd0, e_r2});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ifid(input logic [4:0] op, input logic [3:0] r1, input logic [3:0] r2);
    ifid_opcode = op; ifid_r1 = r1; ifid_r2 = r2;
  endtask

  task automatic set_idex(input logic [4:0] op, input logic [2:0] rd,
                          input logic [3:0] r1, input logic [3:0] r2);
    idex_opcode = op; idex_rd = rd; idex_r1 = r1; idex_r2 = r2;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset held with a live load-use hazard on the inputs: outputs forced idle.
    rst = 1'b0;
    branch_taken = 1'b1;
    set_ifid(5'h00, 4'd3, 4'd0);
    set_idex(5'h08, 3'd3, 4'd0, 4'd0);
    #1;
    chk_all("reset", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);

    step();
    rst = 1'b1;
    branch_taken = 1'b0;
    set_ifid(5'h1f, 4'd0, 4'd0);
    set_idex(5'h1f, 3'd0, 4'd0, 4'd0);
    #1;
    chk_all("idle", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);

    // Load-use on r1: one bubble cycle, then cleared once ID/EX holds the bubble.
    set_ifid(5'h00, 4'd3, 4'd0);
    set_idex(5'h08, 3'd3, 4'd1, 4'd2);
    #1;
    chk_all("ld_use_r1", 1, 0, 1, 5'h1f, 3'd0, 4'd0, 4'd0);
    step();
    set_idex(5'h1f, 3'd0, 4'd0, 4'd0);
    #1;
    chk_all("ld_use_after", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);

    // Load-use on r2, suppressed when IF/ID is a NOP.
    step();
    set_ifid(5'h09, 4'd7, 4'd5);
    set_idex(5'h08, 3'd5, 4'd0, 4'd0);
    #1;
    chk("ld_use_r2.stall", {31'd0, stall}, 32'd1);
    set_ifid(5'h1f, 4'd7, 4'd5);
    #1;
    chk("ld_use_r2_nop.stall", {31'd0, stall}, 32'd0);

    // Load to r0 never stalls.
    set_ifid(5'h00, 4'd0, 4'd0);
    set_idex(5'h08, 3'd0, 4'd0, 4'd0);
    #1;
    chk("ld_r0.stall", {31'd0, stall}, 32'd0);
    chk("ld_r0.pc_hold", {31'd0, pc_hold}, 32'd0);

    // MUL with MUL_CYCLES=3: two stall cycles replaying (04,2,4,5), then free.
    step();
    set_ifid(5'h1f, 4'd0, 4'd0);
    set_idex(5'h04, 3'd2, 4'd4, 4'd5);
    #1;
    chk_all("mul_c0", 1, 0, 1, 5'h04, 3'd2, 4'd4, 4'd5);
    chk("mul1_c0.stall", {31'd0, u1_stall}, 32'd0);
    chk("mul1_c0.pc_hold", {31'd0, u1_pc_hold}, 32'd0);
    step();
    chk_all("mul_c1", 1, 0, 1, 5'h04, 3'd2, 4'd4, 4'd5);
    chk("mul1_c1.stall", {31'd0, u1_stall}, 32'd0);
    step();
    chk_all("mul_c2", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    step();
    set_idex(5'h1f, 3'd0, 4'd0, 4'd0);
    #1;
    chk("mul_c3.stall", {31'd0, stall}, 32'd0);

    // Branch taken: FLUSH for the detect cycle and FLUSH2, even if BEQ lingers.
    step();
    set_idex(5'h10, 3'd0, 4'd1, 4'd2);
    branch_taken = 1'b1;
    #1;
    chk_all("br_c0", 0, 1, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    chk("br1_c0.flush", {31'd0, u1_flush}, 32'd1);
    step();
    chk_all("br_c1", 0, 1, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    step();
    set_idex(5'h1f, 3'd0, 4'd0, 4'd0);
    #1;
    chk_all("br_nop", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    branch_taken = 1'b0;

    // Reset in MULBUSY (cnt=1) kills outputs immediately; stays quiet after release.
    step();
    set_idex(5'h04, 3'd6, 4'd7, 4'd8);
    step();
    chk("rstmul_busy.stall", {31'd0, stall}, 32'd1);
    chk("rstmul_busy.op", {27'd0, s_op}, 32'h04);
    rst = 1'b0;
    #1;
    chk_all("rstmul_async", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    step();
    set_idex(5'h1f, 3'd0, 4'd0, 4'd0);
    rst = 1'b1;
    #1;
    chk_all("rstmul_rel", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);
    step();
    chk_all("rstmul_rel2", 0, 0, 0, 5'h1f, 3'd0, 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
